// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: row strobing, debounced press/release detection and a key event FIFO.
// Define KEYPAD_AUTOREPEAT_EN to re-queue a held key after REPEAT_FIRST ticks, then every REPEAT_NEXT ticks.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int REPEAT_FIRST   = 64,
    parameter int REPEAT_NEXT    = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] column,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_down,
    output logic       overflow,
    input  logic       clr_overflow
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_DONE   = DB_W'(DEBOUNCE_SCANS);
    localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0] KEY_MAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                            4'h4, 4'h5, 4'h6, 4'hB,
                                            4'h7, 4'h8, 4'h9, 4'hC,
                                            4'hE, 4'h0, 4'hF, 4'hD};

    if (SCAN_DIV < 4) begin : g_bad_div
        $error("SCAN_DIV must be at least 4");
    end
    if (DEBOUNCE_SCANS < 1) begin : g_bad_db
        $error("DEBOUNCE_SCANS must be at least 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end
    if (REPEAT_FIRST < 1 || REPEAT_NEXT < 1) begin : g_bad_rpt
        $error("REPEAT_FIRST and REPEAT_NEXT must be at least 1");
    end

    // state    | meaning
    // SCAN     | rotating the low row, looking for any low column
    // DEBOUNCE | row held, counting identical press samples
    // PRESSED  | key accepted and queued, waiting for all columns high
    // RELEASE  | counting all-high samples before the scan resumes
    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    logic [3:0]       col_s1_q, col_s2_q;
    logic [DIV_W-1:0] div_q, div_d;
    state_t           state_q, state_d;
    logic [3:0]       row_q, row_d;
    logic [DB_W-1:0]  deb_q, deb_d;
    logic [3:0]       code_q, code_d;
    logic [1:0]       win_q, win_d;
    logic             key_down_q, key_down_d;
    logic [3:0]       mem_q [FIFO_DEPTH];
    logic [3:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             tick, any_low, fsm_push, push, pop, full, wr_en;
    logic [1:0]       col_win, row_idx;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_FIRST > REPEAT_NEXT) ? REPEAT_FIRST : REPEAT_NEXT;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_FIRST_L = RPT_W'(REPEAT_FIRST);
    localparam logic [RPT_W-1:0] RPT_NEXT_L  = RPT_W'(REPEAT_NEXT);
    localparam logic [RPT_W-1:0] RPT_ONE     = RPT_W'(1);
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_push;
`endif

    always_comb begin
        any_low = (col_s2_q != 4'hF);
        col_win = 2'd3;
        if (!col_s2_q[2]) col_win = 2'd2;
        if (!col_s2_q[1]) col_win = 2'd1;
        if (!col_s2_q[0]) col_win = 2'd0;
        case (row_q)
            4'b0111: row_idx = 2'd0;
            4'b1011: row_idx = 2'd1;
            4'b1101: row_idx = 2'd2;
            default: row_idx = 2'd3;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        deb_d      = deb_q;
        code_d     = code_q;
        win_d      = win_q;
        key_down_d = key_down_q;
        fsm_push   = 1'b0;
        tick       = (div_q == DIV_LAST);
        div_d      = tick ? '0 : div_q + 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
        rpt_d      = rpt_q;
        rpt_push   = 1'b0;
`endif
        case (state_q)
            SCAN: if (tick) begin
                if (any_low) begin
                    code_d  = KEY_MAP[{row_idx, col_win}];
                    win_d   = col_win;
                    deb_d   = DB_ONE;
                    state_d = DEBOUNCE;
                end else begin
                    row_d = {row_q[0], row_q[3:1]};
                end
            end
            // Acceptance is checked off-tick so the push lands one cycle after the final sample.
            DEBOUNCE: if (deb_q == DB_DONE) begin
                fsm_push   = 1'b1;
                key_down_d = 1'b1;
                state_d    = PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
                rpt_d      = RPT_FIRST_L;
`endif
            end else if (tick) begin
                if (any_low && col_win == win_q) deb_d = deb_q + 1'b1;
                else                             state_d = SCAN;
            end
            PRESSED: if (tick) begin
                if (!any_low) begin
                    deb_d = DB_ONE;
                    if (DB_DONE == DB_ONE) begin
                        key_down_d = 1'b0;
                        row_d      = {row_q[0], row_q[3:1]};
                        state_d    = SCAN;
                    end else begin
                        state_d = RELEASE;
                    end
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                else if (rpt_q == RPT_ONE) begin
                    rpt_push = 1'b1;
                    rpt_d    = RPT_NEXT_L;
                end else begin
                    rpt_d = rpt_q - 1'b1;
                end
`endif
            end
            RELEASE: if (tick) begin
                if (any_low) begin
                    state_d = PRESSED;
                end else if (deb_q + 1'b1 == DB_DONE) begin
                    key_down_d = 1'b0;
                    row_d      = {row_q[0], row_q[3:1]};
                    state_d    = SCAN;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
`ifdef KEYPAD_AUTOREPEAT_EN
        push = fsm_push | rpt_push;
`else
        push = fsm_push;
`endif
        pop   = key_ack & (cnt_q != '0);
        full  = (cnt_q == FIFO_FULL);
        wr_en = push & (~full | pop);
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (wr_en) begin
            mem_d[wr_q] = code_q;
            wr_d        = wr_q + 1'b1;
        end
        if (pop) rd_d = rd_q + 1'b1;
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        ovf_d = (push & full & ~pop) | (ovf_q & ~clr_overflow);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_s1_q   <= 4'hF;
            col_s2_q   <= 4'hF;
            div_q      <= '0;
            state_q    <= SCAN;
            row_q      <= 4'b0111;
            deb_q      <= '0;
            code_q     <= 4'h0;
            win_q      <= 2'd0;
            key_down_q <= 1'b0;
            mem_q      <= '{default: 4'h0};
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_q      <= '0;
`endif
        end else begin
            col_s1_q   <= column;
            col_s2_q   <= col_s1_q;
            div_q      <= div_d;
            state_q    <= state_d;
            row_q      <= row_d;
            deb_q      <= deb_d;
            code_q     <= code_d;
            win_q      <= win_d;
            key_down_q <= key_down_d;
            mem_q      <= mem_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_q      <= rpt_d;
`endif
        end
    end

    assign row       = row_q;
    assign key_code  = mem_q[rd_q];
    assign key_valid = (cnt_q != '0);
    assign key_down  = key_down_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Autonomous scan controller for the 4x4 matrix keypad on the MAX1000 Nios labs.
- Drives the active-low row strobes and samples the active-low columns.
- Debounces press and release, then encodes the key.
- Queues key events in a small FIFO that the Nios PIO/Avalon side pops with a valid/ack handshake, so software never misses or double-counts a press.

Parameters:
SCAN_DIV, 50000, clock cycles per row dwell; a "tick" fires on the last cycle of each dwell; minimum 4.
DEBOUNCE_SCANS, 4, consecutive identical tick samples needed to accept a press or a release; minimum 1.
FIFO_DEPTH, 4, key event queue depth; power of two, minimum 2.
REPEAT_FIRST, 64, ticks held before the first auto-repeat (used only with the macro).
REPEAT_NEXT, 16, ticks between later auto-repeats (used only with the macro).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
column  in  4  keypad columns C1..C4 = column[0..3]; active-low, asynchronous
row  out  4  keypad rows R1..R4 = row[0..3]; exactly one bit low at all times
key_code  out  4  code at the FIFO head
key_valid  out  1  FIFO not empty
key_ack  in  1  pop the FIFO head when key_valid=1
key_down  out  1  a debounced key is currently held
overflow  out  1  sticky; an event was dropped because the FIFO was full
clr_overflow  in  1  clears overflow

Behaviour:
- Reset values: row=4'b0111, key_code=0, key_valid=0, key_down=0, overflow=0, FIFO empty, state SCAN, dwell counter 0, debounce counter 0.
- Input sync: column passes through a 2-flop synchronizer. All samples use the synchronized value, and only on tick cycles.
- Key map (row, column -> code):
  - Row 0: 1, 2, 3, A
  - Row 1: 4, 5, 6, B
  - Row 2: 7, 8, 9, C
  - Row 3: E(*), 0, F(#), D
- Column priority: if several columns are low, the lowest-index low column wins.
- State SCAN:
  - On a tick with all columns high, rotate the low bit 0111 -> 1011 -> 1101 -> 1110 -> 0111.
  - On a tick with any column low, hold the row, capture the code, set the debounce count to 1, and go to DEBOUNCE.
- State DEBOUNCE:
  - Row is held.
  - Tick where the same winning column is still low: increment the count.
  - Tick with a different winning column, or all columns high: return to SCAN; the row advances on the next empty tick.
  - When the count reaches DEBOUNCE_SCANS: push the code on the next clk cycle, set key_down=1, go to PRESSED.
  - If DEBOUNCE_SCANS=1, the push follows the first detecting tick directly.
- State PRESSED:
  - Row is held.
  - A tick with all columns high sets the release count to 1 and moves to RELEASE.
  - A change to a different column while held is ignored; no second event is generated.
- State RELEASE:
  - Count consecutive all-high ticks.
  - Any low column returns to PRESSED without a new event.
  - At DEBOUNCE_SCANS: key_down=0, rotate to the next row, go to SCAN.
- FIFO:
  - key_code shows the head combinationally from registered storage.
  - Pop occurs on a clk edge with key_valid & key_ack; key_ack while empty is ignored.
  - Push when full with no pop: the event is dropped and overflow is set.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Push into an empty FIFO: key_valid rises on the following cycle.
- Overflow: clr_overflow clears it. A set and a clear in the same cycle leaves it set.
- Reset asserted mid-operation: all state is reset immediately, the FIFO is flushed, and any pending event is lost.

Optional Feature:
Macro KEYPAD_AUTOREPEAT_EN.
- Defined: in PRESSED, a held-tick counter pushes the same code again after REPEAT_FIRST ticks, then every REPEAT_NEXT ticks. The counter resets on entry to PRESSED. Ticks spent in RELEASE before bouncing back do not reset it. Repeats obey the FIFO overflow rules.
- Undefined: exactly one event per debounced press; the counter logic is absent.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_SCANS=3, FIFO_DEPTH=4.
1. Idle, all columns high, 40 clks after reset release -> row cycles 0111, 1011, 1101, 1110, 0111, changing every 4 clks; key_valid=0.
2. Hold column[1] low while row=1011 for 5 ticks -> row stays 1011, key_down=1, exactly one event with key_code=4'h5 and key_valid=1. Release for 3 ticks -> key_down=0, row advances to 1101.
3. column[2] low for 2 ticks then high on row 0111 -> no event; scanning resumes.
4. Press row 1110 with column[0] and column[3] low together -> key_code=4'hE (lowest column wins); a single event.
5. Five distinct presses with key_ack held at 0 -> four events queued, overflow=1, head=first key. Pulse key_ack 4 times -> codes pop in press order, then key_valid=0. Pulse clr_overflow -> overflow=0.
6. With KEYPAD_AUTOREPEAT_EN and REPEAT_FIRST=8, REPEAT_NEXT=4: hold 4'h1 for 20 ticks after acceptance -> events at 0, 8, 12, 16, 20 ticks (FIFO full, fifth dropped, overflow=1). Assert reset_n low mid-hold -> all outputs return to reset values at once.
